// File: rtl/pci_phy_pkg.sv
// Shared definitions for the PCI physical-layer serializer/deserializer pair.
package pci_phy_pkg;

  // K28.5 comma byte used for alignment and idle fill.
  localparam logic [7:0] K28_5 = 8'hBC;

  // Number of commas sent after reset before data may go out.
  localparam int unsigned DEFAULT_PREAMBLE_BC = 8;

  typedef enum logic {
    PREAMBLE = 1'b0,
    RUN      = 1'b1
  } tx_state_t;

endpackage

// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter: MSB-first, one bit per clk_32f cycle,
// comma preamble after reset and comma fill whenever no byte is available.
module paralelo_serial
  import pci_phy_pkg::*;
#(
  parameter int unsigned PREAMBLE_BC = DEFAULT_PREAMBLE_BC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       data_out,
  output logic       active,
  output logic       byte_start
);

  localparam int unsigned CW = $clog2(PREAMBLE_BC + 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] pre_cnt, pre_nxt;
  logic [2:0]    bit_cnt;
  logic [6:0]    remainder;
  logic [7:0]    hold_data, hold_data_nxt;
  logic          hold_full, hold_full_nxt;

  logic          boundary;
  logic          to_run;
  logic          accept;
  logic          bypass;
  logic [7:0]    load_byte;

  assign boundary = (bit_cnt == 3'd7);
  assign to_run   = (state == PREAMBLE) && (pre_cnt == CW'(PREAMBLE_BC));
  assign accept   = valid_in && !hold_full;
  assign ready    = !hold_full;
  assign active   = (state == RUN);

  // State register.
  always_ff @(posedge clk_32f) begin
    if (reset) state <= PREAMBLE;
    else       state <= state_nxt;
  end

  // Next state, byte selection at boundaries and hold-buffer control.
  always_comb begin
    state_nxt     = state;
    pre_nxt       = pre_cnt;
    hold_full_nxt = hold_full;
    hold_data_nxt = hold_data;
    load_byte     = K28_5;
    bypass        = 1'b0;

    if (boundary) begin
      if (to_run) state_nxt = RUN;

      if (state == PREAMBLE && !to_run) begin
        load_byte = K28_5;
        pre_nxt   = pre_cnt + CW'(1);
      end else if (hold_full) begin
        load_byte     = hold_data;
        hold_full_nxt = 1'b0;
      end else if (accept) begin
        load_byte = data_in;
        bypass    = 1'b1;
      end else begin
        load_byte = K28_5;
      end
    end

    // An accepted byte that did not go straight into the shifter waits here.
    if (accept && !bypass) begin
      hold_data_nxt = data_in;
      hold_full_nxt = 1'b1;
    end
  end

  // Preamble counter and hold buffer.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      pre_cnt   <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      pre_cnt   <= pre_nxt;
      hold_full <= hold_full_nxt;
      hold_data <= hold_data_nxt;
    end
  end

  // Shifter: load a new byte at each boundary, otherwise shift out the remainder.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      data_out   <= 1'b0;
      byte_start <= 1'b0;
      remainder  <= '0;
      bit_cnt    <= 3'd7;
    end else if (boundary) begin
      data_out   <= load_byte[7];
      remainder  <= load_byte[6:0];
      bit_cnt    <= 3'd0;
      byte_start <= 1'b1;
    end else begin
      data_out   <= remainder[6];
      remainder  <= {remainder[5:0], 1'b0};
      bit_cnt    <= bit_cnt + 3'd1;
      byte_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Self-checking bench for paralelo_serial: per-scenario tasks plus a
// deserializing monitor that pops expected data bytes from a scoreboard.
module tb_paralelo_serial;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       data_out;
  logic       active;
  logic       byte_start;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  logic [7:0] sb_q[$];
  logic [7:0] log_q[$];

  paralelo_serial #(.PREAMBLE_BC(8)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready     (ready),
    .data_out  (data_out),
    .active    (active),
    .byte_start(byte_start)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  // Edge number since reset release: first edge with reset low is 1.
  always @(posedge clk_32f) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // Monitor: frame on byte_start, rebuild bytes, check framing and data order.
  int         mon_pos = -1;
  int         mon_gap = 0;
  bit         mon_gv  = 1'b0;
  logic [7:0] mon_sr;
  logic [7:0] mon_exp;

  always @(negedge clk_32f) begin
    if (reset) begin
      mon_pos = -1;
      mon_gv  = 1'b0;
      mon_gap = 0;
    end else begin
      if (byte_start) begin
        if (mon_gv) begin
          n_cmp++;
          if (mon_gap != 8) begin
            n_bad++;
            $display("FAIL framing: byte_start gap %0d, required 8", mon_gap);
          end
        end
        mon_gv  = 1'b1;
        mon_gap = 1;
        mon_pos = 0;
        mon_sr  = {7'b0, data_out};
      end else begin
        mon_gap++;
        if (mon_pos >= 0) begin
          mon_sr  = {mon_sr[6:0], data_out};
          mon_pos++;
        end
      end
      if (mon_pos == 7) begin
        log_q.push_back(mon_sr);
        if (mon_sr != 8'hBC) begin
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_byte: got %02h, required none", mon_sr);
          end else begin
            mon_exp = sb_q.pop_front();
            if (mon_sr !== mon_exp) begin
              n_bad++;
              $display("FAIL data_byte: got %02h, required %02h", mon_sr, mon_exp);
            end
          end
        end
        mon_pos = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int k = 0; k < max_cycles && sb_q.size() != 0; k++) tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d bytes pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset    = 1'b1;
    tick();
    tick();
    n_cmp += 4;
    if (data_out !== 1'b0)   begin n_bad++; $display("FAIL rst_data_out: got %b, required 0", data_out); end
    if (byte_start !== 1'b0) begin n_bad++; $display("FAIL rst_byte_start: got %b, required 0", byte_start); end
    if (active !== 1'b0)     begin n_bad++; $display("FAIL rst_active: got %b, required 0", active); end
    if (ready !== 1'b1)      begin n_bad++; $display("FAIL rst_ready: got %b, required 1", ready); end
    reset = 1'b0;
    log_q.delete();
  endtask

  task automatic test_idle();
    logic [7:0] bc;
    int         pos;
    bc = 8'hBC;
    for (int i = 0; i < 100; i++) begin
      tick();
      pos = (edge_n - 1) % 8;
      n_cmp += 3;
      if (active !== (edge_n >= 65)) begin
        n_bad++; $display("FAIL idle_active: edge %0d got %b, required %b", edge_n, active, edge_n >= 65);
      end
      if (data_out !== bc[7-pos]) begin
        n_bad++; $display("FAIL idle_bit: edge %0d got %b, required %b", edge_n, data_out, bc[7-pos]);
      end
      if (byte_start !== (pos == 0)) begin
        n_bad++; $display("FAIL idle_byte_start: edge %0d got %b, required %b", edge_n, byte_start, pos == 0);
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] pat;
    pat = 8'hA5;
    for (int k = 0; k < 8 && (edge_n % 8) != 0; k++) tick();
    data_in  = pat;
    valid_in = 1'b1;
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL bypass_ready_pre: got %b, required 1", ready); end
    sb_q.push_back(pat);
    for (int i = 0; i < 8; i++) begin
      tick();
      valid_in = 1'b0;
      n_cmp += 3;
      if (data_out !== pat[7-i]) begin
        n_bad++; $display("FAIL bypass_bit%0d: got %b, required %b", i, data_out, pat[7-i]);
      end
      if (ready !== 1'b1) begin
        n_bad++; $display("FAIL bypass_ready%0d: got %b, required 1", i, ready);
      end
      if (byte_start !== (i == 0)) begin
        n_bad++; $display("FAIL bypass_byte_start%0d: got %b, required %b", i, byte_start, i == 0);
      end
    end
    wait_drain(32);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int         idx;
    int         found;
    bit         r;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    for (int k = 0; k < 8 && (edge_n % 8) != 3; k++) tick();
    log_q.delete();
    idx      = 0;
    data_in  = bytes[0];
    valid_in = 1'b1;
    for (int c = 0; c < 64 && idx < 3; c++) begin
      r = ready;
      tick();
      if (r) begin
        sb_q.push_back(data_in);
        if (((edge_n - 1) % 8) != 0) begin
          n_cmp++;
          if (ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_ready_drop%0d: got %b, required 0", idx, ready);
          end
        end
        idx++;
        if (idx < 3) data_in = bytes[idx];
        else         valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    n_cmp++;
    if (idx != 3) begin n_bad++; $display("FAIL b2b_accept: got %0d accepted, required 3", idx); end
    wait_drain(64);
    found = -1;
    foreach (log_q[i]) if (found < 0 && log_q[i] == 8'h01) found = i;
    n_cmp += 3;
    if (found < 0 || found + 2 >= log_q.size()) begin
      n_bad++; $display("FAIL b2b_sequence: got index %0d of %0d, required complete run", found, log_q.size());
    end else begin
      if (log_q[found+1] !== 8'h02) begin n_bad++; $display("FAIL b2b_second: got %02h, required 02", log_q[found+1]); end
      if (log_q[found+2] !== 8'h03) begin n_bad++; $display("FAIL b2b_third: got %02h, required 03", log_q[found+2]); end
    end
  endtask

  task automatic test_preamble_hold();
    do_reset();
    for (int k = 0; k < 20 && edge_n < 10; k++) tick();
    data_in  = 8'h5A;
    valid_in = 1'b1;
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL pre_ready_pre: got %b, required 1", ready); end
    tick();
    valid_in = 1'b0;
    sb_q.push_back(8'h5A);
    while (edge_n < 70) begin
      n_cmp++;
      if (ready !== (edge_n >= 65)) begin
        n_bad++; $display("FAIL pre_ready: edge %0d got %b, required %b", edge_n, ready, edge_n >= 65);
      end
      if (edge_n == 65) begin
        n_cmp += 3;
        if (active !== 1'b1)     begin n_bad++; $display("FAIL pre_active65: got %b, required 1", active); end
        if (data_out !== 1'b0)   begin n_bad++; $display("FAIL pre_msb65: got %b, required 0", data_out); end
        if (byte_start !== 1'b1) begin n_bad++; $display("FAIL pre_start65: got %b, required 1", byte_start); end
      end
      tick();
    end
    wait_drain(32);
    n_cmp++;
    if (log_q.size() < 9) begin
      n_bad++; $display("FAIL pre_first_run_byte: got %0d bytes, required at least 9", log_q.size());
    end else if (log_q[8] !== 8'h5A) begin
      n_bad++; $display("FAIL pre_first_run_byte: got %02h, required 5a", log_q[8]);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8 && (edge_n % 8) != 2; k++) tick();
    data_in  = 8'h3C;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_hold_ready: got %b, required 0", ready); end
    reset = 1'b1;
    tick();
    n_cmp += 3;
    if (data_out !== 1'b0) begin n_bad++; $display("FAIL mid_data_out: got %b, required 0", data_out); end
    if (ready !== 1'b1)    begin n_bad++; $display("FAIL mid_ready: got %b, required 1", ready); end
    if (active !== 1'b0)   begin n_bad++; $display("FAIL mid_active: got %b, required 0", active); end
    reset = 1'b0;
    log_q.delete();
    for (int k = 0; k < 90; k++) tick();
    n_cmp += 2;
    if (active !== 1'b1) begin n_bad++; $display("FAIL mid_reactive: got %b, required 1", active); end
    foreach (log_q[i]) begin
      if (log_q[i] != 8'hBC) begin
        n_bad++; $display("FAIL mid_discard: got %02h at %0d, required only commas", log_q[i], i);
        break;
      end
    end
  endtask

  task automatic test_random();
    int  sent;
    bit  r;
    sent = 0;
    for (int c = 0; c < 2000 && sent < 24; c++) begin
      if (!valid_in && ($urandom % 2 == 0)) begin
        data_in = 8'($urandom_range(0, 254));
        if (data_in == 8'hBC) data_in = 8'hBD;
        valid_in = 1'b1;
      end
      r = ready;
      tick();
      if (valid_in && r) begin
        sb_q.push_back(data_in);
        valid_in = 1'b0;
        sent++;
      end
    end
    valid_in = 1'b0;
    n_cmp++;
    if (sent != 24) begin n_bad++; $display("FAIL rand_accept: got %0d, required 24", sent); end
    wait_drain(400);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    test_reset();
    test_idle();
    test_bypass();
    test_back_to_back();
    test_preamble_hold();
    test_reset_mid();
    test_random();
    for (int k = 0; k < 16; k++) tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL final_scoreboard: got %0d pending, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Byte-to-serial transmitter for the PCI physical-layer link, running on the bit clock `clk_32f`. It accepts bytes over a valid/ready handshake, serializes them MSB first at one bit per cycle, and fills every gap with the K28.5 comma byte 0xBC. After reset it sends a fixed comma preamble so the `serial_paralelo` receiver can align its byte boundary and raise its own `active`.

## Interface
- `PREAMBLE_BC`, default 8: number of 0xBC commas sent after reset before any data byte can be sent. Legal range 5..255.
- `clk_32f`  in  1  bit clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  8  byte to transmit.
- `valid_in`  in  1  `data_in` is valid.
- `ready`  out  1  transmitter can take a byte this cycle.
- `data_out`  out  1  serial line, registered.
- `active`  out  1  preamble complete; data bytes may now go out.
- `byte_start`  out  1  `data_out` currently carries bit 7 of a byte (data or comma).

## Operation
- Single clock (`clk_32f`). Reset is synchronous and active-high.
- State machine:
  - States: PREAMBLE (after reset) and RUN. There is no path from RUN back to PREAMBLE except reset.
  - PREAMBLE → RUN on the byte boundary where the count of preamble commas loaded equals `PREAMBLE_BC`.
  - `active` = (state == RUN).
- Datapath:
  - 7-bit shift remainder, 3-bit bit counter `bit_cnt`, one-entry hold buffer (`hold_data`, `hold_full`), preamble counter.
  - A byte boundary is any non-reset cycle with `bit_cnt == 7`.
- At a boundary, the next byte is chosen in this priority:
  1. State PREAMBLE (and not transitioning): load 0xBC and increment the preamble counter.
  2. RUN with `hold_full`: load `hold_data` and clear `hold_full`.
  3. RUN with `valid_in && ready`: bypass, loading `data_in` directly; the hold buffer is not written.
  4. Otherwise: load 0xBC (idle comma).
- On a load edge:
  - `data_out` ← byte[7], remainder ← byte[6:0], `bit_cnt` ← 0, `byte_start` ← 1.
- On a non-boundary edge:
  - `data_out` ← remainder MSB, remainder shifts left, `bit_cnt`++, `byte_start` ← 0.
- Handshake:
  - `ready` = !`hold_full`, taken from a register with no combinational path from `valid_in`.
  - A byte is accepted on any edge where `valid_in && ready`. If the bypass does not apply, it goes into the hold buffer.
  - `data_in` is sampled only on the accept edge.
  - While `hold_full`, `valid_in` is ignored and the upstream block must hold its byte.
- Boundary conditions:
  - Hold buffer full at a boundary: it drains into the shifter. `ready` rises the next cycle.
  - Bytes accepted during PREAMBLE wait in the hold buffer. The first one becomes the first RUN byte.
  - A data value of 0xBC is sent unchanged. Upstream logic must not send it, because the receiver treats it as a comma.
  - Reset mid-byte: the current byte is abandoned, the held byte is discarded, and the preamble restarts.

## Timing
- Reset values:
  - `data_out`=0, `byte_start`=0, `active`=0, `ready`=1.
  - `hold_full`=0, `bit_cnt`=7, preamble counter=0, state=PREAMBLE.
- Startup: the first edge with `reset`=0 is edge 1 and is a boundary.
  - Commas occupy `data_out` from edges 1 through 8·`PREAMBLE_BC`.
  - Edge 8·`PREAMBLE_BC`+1 switches to RUN, sets `active`=1 and loads under the RUN rules.
- Latency:
  - Bypass: the MSB appears on `data_out` after the accept edge.
  - Held byte: the MSB appears after the next boundary edge.
- Throughput: one byte per 8 cycles, with no bit gaps. Continuous `valid_in` produces a comma-free stream.
- Framing: `byte_start` is high exactly every 8th cycle once out of reset.

## Structure
- Shared package `pci_phy_pkg` holds:
  - `K28_5 = 8'hBC`
  - the state enum (PREAMBLE, RUN)
  - `DEFAULT_PREAMBLE_BC = 8`
- The `serial_paralelo` receiver uses the same `K28_5` constant.
- Flat single module; no sub-module is warranted. The preamble counter width is `$clog2(PREAMBLE_BC+1)`.

## Test plan
- Reset, then idle for 100 cycles → `data_out` repeats 10111100 with `byte_start` every 8 cycles, and `active` rises at edge 65.
- In RUN, 0xA5 arrives exactly at a boundary with the hold buffer empty → bypass; bits 1,0,1,0,0,1,0,1 appear on edges E..E+7, with `ready` staying 1.
- Back-to-back 0x01, 0x02, 0x03 with `valid_in` held high → `ready` drops after each hold write and no commas appear between the bytes.
- 0x5A presented during PREAMBLE → accepted and held, `ready`=0 until edge 65; it is the first byte after the preamble.
- `reset` asserted mid-byte in RUN while the hold buffer is full → the next cycle shows `data_out`=0, `ready`=1, `active`=0, and the held byte never appears.
- Loopback into `serial_paralelo` with random bytes excluding 0xBC → the receiver's `active` rises and its `data_out` matches the sent sequence in order.
